// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS datapath memory stage:
//   - primary opcodes of the memory instructions (plus the immediate ALU ops
//     ORI/ANDI that other stages already decode);
//   - FSM state encoding of the memory-alignment unit;
//   - byte-enable constants, bit i enables bits 8i+7:8i;
//   - helpers that classify an opcode into access size / direction and check
//     alignment of a byte offset for that size.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } fsmState;

  // SZ_NONE marks an opcode that is not a memory access at all.
  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } accSize;

  function automatic accSize accessSize(input logic [5:0] op);
    accSize sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LW, OP_SW:         sz = SZ_WORD;
      default:              sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic isLoad(input logic [5:0] op);
    logic ld;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: ld = 1'b1;
      default:                             ld = 1'b0;
    endcase
    return ld;
  endfunction

  function automatic logic isStore(input logic [5:0] op);
    logic st;
    case (op)
      OP_SB, OP_SH, OP_SW: st = 1'b1;
      default:             st = 1'b0;
    endcase
    return st;
  endfunction

  function automatic logic isAligned(input accSize sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_HALF: ok = (off[0] == 1'b0);
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// -----------------------------------------------------------------------------
// mem_align_if
// Bundles the core-side request/response signals and the memory-side bus of
// the memory-alignment unit.
//   slave  : the view of mem_align_unit (accepts core requests, drives memory)
//   master : the view of the environment (core + data memory)
// Core side : req_valid, req_ready, opcode, addr, wdata, rd_data, rd_valid,
//             st_done, align_err
// Memory    : mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_ack, mem_rdata
// -----------------------------------------------------------------------------
interface mem_align_if #(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              st_done;
  logic              align_err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, opcode, addr, wdata, mem_ack, mem_rdata,
    output req_ready, rd_data, rd_valid, st_done, align_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, opcode, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, rd_data, rd_valid, st_done, align_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_align_unit_load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational load formatting: picks the addressed byte/halfword out of the
// returned memory word (little-endian lanes) and sign- or zero-extends it.
//   opcode  in  6   load opcode (LB/LH/LW/LBU/LHU)
//   byteOff in  2   addr[1:0] of the access
//   word    in  32  word returned by memory
//   result  out 32  extended load value (word passed through for LW)
// -----------------------------------------------------------------------------
module load_extender
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  byteOff,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Lane select, then extension according to the load flavour.
  always_comb begin
    laneByte = 8'h00;
    laneHalf = 16'h0000;
    result   = word;
    case (byteOff)
      2'd0:    laneByte = word[7:0];
      2'd1:    laneByte = word[15:8];
      2'd2:    laneByte = word[23:16];
      2'd3:    laneByte = word[31:24];
      default: laneByte = 8'h00;
    endcase
    if (byteOff[1]) begin
      laneHalf = word[31:16];
    end else begin
      laneHalf = word[15:0];
    end
    case (opcode)
      OP_LB:   result = {{24{laneByte[7]}}, laneByte};
      OP_LBU:  result = {24'h000000, laneByte};
      OP_LH:   result = {{16{laneHalf[15]}}, laneHalf};
      OP_LHU:  result = {16'h0000, laneHalf};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_align_unit.sv
// -----------------------------------------------------------------------------
// mem_align_unit
// Data-memory access stage: narrows/places store data onto byte lanes with
// byte enables, formats load data, rejects misaligned accesses, and runs a
// single-outstanding request/acknowledge handshake with a variable-latency
// memory.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   bus   mem_align_if.slave: core request/response + memory bus
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_align_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  mem_align_if.slave bus
);

  fsmState stateR;
  fsmState nextState;

  logic              reqReadyR;
  logic              memReqR;
  logic              memWeR;
  logic              rdValidR;
  logic              stDoneR;
  logic              alignErrR;
  logic [3:0]        memBeR;
  logic [ADDR_W-1:0] memAddrR;
  logic [DATA_W-1:0] memWdataR;
  logic [DATA_W-1:0] rdDataR;
  logic [5:0]        opcodeR;
  logic [1:0]        byteOffR;

  accSize            reqSize;
  logic [1:0]        reqOff;
  logic [3:0]        reqBe;
  logic [DATA_W-1:0] reqWdata;
  logic              startMem;
  logic              nextAlignErr;
  logic              nextStDone;
  logic              nextRdValid;
  logic              captureLoad;
  logic [31:0]       loadResult;

  // Lane placement of the incoming request; only used on the accept cycle.
  always_comb begin
    reqSize  = accessSize(bus.opcode);
    reqOff   = bus.addr[1:0];
    reqBe    = 4'b0000;
    reqWdata = '0;
    case (reqSize)
      SZ_BYTE: begin
        case (reqOff)
          2'd0:    reqBe = BE_BYTE0;
          2'd1:    reqBe = BE_BYTE1;
          2'd2:    reqBe = BE_BYTE2;
          2'd3:    reqBe = BE_BYTE3;
          default: reqBe = 4'b0000;
        endcase
      end
      SZ_HALF: reqBe = reqOff[1] ? BE_HALF1 : BE_HALF0;
      SZ_WORD: reqBe = BE_WORD;
      default: reqBe = 4'b0000;
    endcase
    // Narrow data is replicated on every lane; the byte enables pick the lane.
    if (isStore(bus.opcode)) begin
      case (reqSize)
        SZ_BYTE: reqWdata = {4{bus.wdata[7:0]}};
        SZ_HALF: reqWdata = {2{bus.wdata[15:0]}};
        SZ_WORD: reqWdata = bus.wdata;
        default: reqWdata = '0;
      endcase
    end else begin
      reqWdata = '0;
    end
  end

  // Format the returned word using the opcode/offset latched at accept.
  load_extender uLoadExt (
    .opcode  (opcodeR),
    .byteOff (byteOffR),
    .word    (bus.mem_rdata),
    .result  (loadResult)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextState;
    end
  end

  // FSM next-state and per-cycle event decode.
  always_comb begin
    nextState    = stateR;
    startMem     = 1'b0;
    nextAlignErr = 1'b0;
    nextStDone   = 1'b0;
    nextRdValid  = 1'b0;
    captureLoad  = 1'b0;
    case (stateR)
      IDLE: begin
        if (bus.req_valid) begin
          // Non-memory opcodes are swallowed silently.
          if (reqSize == SZ_NONE) begin
            nextState = IDLE;
          end else if (isAligned(reqSize, reqOff)) begin
            nextState = MEM;
            startMem  = 1'b1;
          end else begin
            nextState    = IDLE;
            nextAlignErr = 1'b1;
          end
        end else begin
          nextState = IDLE;
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          if (isLoad(opcodeR)) begin
            nextState   = RESP;
            nextRdValid = 1'b1;
            captureLoad = 1'b1;
          end else begin
            nextState  = IDLE;
            nextStDone = 1'b1;
          end
        end else begin
          nextState = MEM;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output and request registers; memory-side fields only change on accept,
  // so they stay stable for the whole MEM phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqReadyR <= 1'b1;
      memReqR   <= 1'b0;
      memWeR    <= 1'b0;
      memBeR    <= 4'b0000;
      memAddrR  <= '0;
      memWdataR <= '0;
      rdDataR   <= '0;
      rdValidR  <= 1'b0;
      stDoneR   <= 1'b0;
      alignErrR <= 1'b0;
      opcodeR   <= 6'h00;
      byteOffR  <= 2'b00;
    end else begin
      reqReadyR <= (nextState == IDLE);
      memReqR   <= (nextState == MEM);
      rdValidR  <= nextRdValid;
      stDoneR   <= nextStDone;
      alignErrR <= nextAlignErr;
      if (startMem) begin
        memWeR    <= isStore(bus.opcode);
        memBeR    <= reqBe;
        memAddrR  <= {bus.addr[ADDR_W-1:2], 2'b00};
        memWdataR <= reqWdata;
        opcodeR   <= bus.opcode;
        byteOffR  <= reqOff;
      end
      if (captureLoad) begin
        rdDataR <= loadResult;
      end
    end
  end

  assign bus.req_ready = reqReadyR;
  assign bus.mem_req   = memReqR;
  assign bus.mem_we    = memWeR;
  assign bus.mem_be    = memBeR;
  assign bus.mem_addr  = memAddrR;
  assign bus.mem_wdata = memWdataR;
  assign bus.rd_data   = rdDataR;
  assign bus.rd_valid  = rdValidR;
  assign bus.st_done   = stDoneR;
  assign bus.align_err = alignErrR;

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Data-memory access stage of the MIPS datapath, between the ALU (effective address) and the data memory.
- Store path narrows a 32-bit register value to byte, halfword or word and places it on the correct lanes with byte enables.
- Load path selects the addressed byte or halfword from the returned word and sign- or zero-extends it to 32 bits.
- Runs a one-outstanding request/acknowledge handshake with a variable-latency memory.

Parameters:
- ADDR_W, 32, width of byte address and mem_addr.
- DATA_W, 32, datapath width; fixed at 32, lane logic assumes 4 bytes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a load/store request.
- req_ready  out  1  unit can accept a request (state IDLE).
- opcode  in  6  MIPS primary opcode of the memory instruction.
- addr  in  ADDR_W  byte effective address.
- wdata  in  32  register value to store.
- rd_data  out  32  extended load result; valid only with rd_valid.
- rd_valid  out  1  one-cycle pulse, load result available.
- st_done  out  1  one-cycle pulse, store acknowledged by memory.
- align_err  out  1  one-cycle pulse, misaligned access rejected.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables; bit i = bits 8i+7:8i.
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0).
- mem_wdata  out  32  lane-placed store data.
- mem_ack  in  1  memory completes the current request; rdata valid same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2b. Any other opcode is accepted and dropped: no memory access, no pulse.
- Byte order is little-endian: addr[1:0]=0 selects bits 7:0.
- Alignment rules:
  - Halfword accesses need addr[0]=0.
  - Word accesses need addr[1:0]=0.
  - A violation is accepted, pulses align_err for 1 cycle (the cycle after accept) and issues no memory access.
- Store lanes:
  - SB: mem_be = 1<<addr[1:0], wdata[7:0] replicated on all 4 lanes.
  - SH: mem_be = 0011 or 1100 by addr[1], wdata[15:0] replicated on both halves.
  - SW: mem_be = 1111, data as-is.
- Load extension:
  - Select the lane by addr[1:0] (byte) or addr[1] (halfword).
  - LB/LH replicate bit 7/15 into the upper bits.
  - LBU/LHU zero-fill.
  - For LW, mem_be = 1111.
- FSM states: IDLE, MEM, RESP.
  - IDLE: req_ready=1. On req_valid, register opcode, addr and wdata. An aligned valid access goes to MEM; everything else stays in IDLE (align_err pulse if misaligned).
  - MEM: mem_req=1 with stable mem_we, mem_be, mem_addr, mem_wdata until mem_ack.
    - On ack for a load: capture the extended result and go to RESP.
    - On ack for a store: pulse st_done next cycle and go to IDLE.
  - RESP: rd_valid=1 for exactly 1 cycle, then IDLE.
- Latency: accept at cycle T; mem_req asserted from T+1. With ack at T+1, rd_valid or st_done is asserted at T+2. The next accept is at T+2 for a store and T+3 for a load.
- req_ready is low in MEM and RESP. The core must hold requests until accepted.
- mem_ack outside MEM is ignored.
- Reset values (asynchronous, immediate): state IDLE; req_ready=1; every other output 0, including rd_data, mem_*, pulses.
- Reset asserted mid-MEM drops mem_req at once. The abandoned transaction is not retried; the memory must tolerate a withdrawn request.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (LB…SW, plus the existing ORI/ANDI);
  - FSM state encoding;
  - byte-enable constants BE_BYTE0…BE_WORD.
- Sub-module load_extender: combinational lane select plus sign/zero extend (opcode, addr[1:0], word in; 32-bit result out).
- Store lane placement stays inline.

Test Plan:
- SB opcode 0x28, addr 0x1003, wdata 0x000000A5 -> mem_addr 0x1000, mem_be 1000, mem_wdata 0xA5A5A5A5, st_done 1 cycle after ack.
- LB addr 0x2001, mem_rdata 0x1234_80FF -> rd_data 0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LH addr 0x2002, mem_rdata 0x8001_7FFF -> 0xFFFF8001. LHU same -> 0x00008001. Check rd_valid at T+2 with ack at T+1.
- SH addr 0x3001 and LW addr 0x3002 -> align_err pulse, mem_req never asserted, req_ready stays 1.
- Ack delayed 5 cycles on SW addr 0x4000: mem_* stable throughout, req_ready 0, and req_valid held during the wait is not accepted until IDLE.
- Assert rst_n=0 during MEM -> mem_req and all outputs 0 asynchronously. After release, an LW 0x0 with mem_rdata 0xDEADBEEF returns 0xDEADBEEF.
